// File: rtl/fmul_share_arbiter.sv
// fmul_share_arbiter: shares one combinational float multiplier among NUM_REQ
// requesters. Stage S1 registers the granted operands feeding the multiplier,
// stage S2 registers the product and routes it back to the issuing requester.
// Full valid/ready backpressure; up to two products in flight.
// Optional feature: define FMUL_ARB_RR_EN for round-robin arbitration;
// without it the lowest requesting index always wins.
module fmul_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int E          = 8,
    parameter int M          = 23,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [DATA_WIDTH-1:0]         mul_in1,
    output logic [DATA_WIDTH-1:0]         mul_in2,
    input  logic [DATA_WIDTH-1:0]         mul_out,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic                          busy
);

    // Parameter sanity: E and M only describe the multiplier's float format,
    // so they are checked against the word width here.
    if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
        $error("fmul_share_arbiter: ID_W must equal $clog2(NUM_REQ)");
    end
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("fmul_share_arbiter: NUM_REQ must be in 2..16");
    end
    if (1 + E + M != DATA_WIDTH) begin : g_bad_fmt
        $error("fmul_share_arbiter: 1+E+M must equal DATA_WIDTH");
    end

    // Pipeline registers
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d;
    logic [DATA_WIDTH-1:0] s1_b_q, s1_b_d;
    logic [ID_W-1:0]       s1_id_q, s1_id_d;
    logic                  s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
    logic [ID_W-1:0]       s2_id_q, s2_id_d;
`ifdef FMUL_ARB_RR_EN
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
`endif

    // Flow control
    logic                  s2_drain;
    logic                  s2_free;
    logic                  s1_adv;
    logic                  s1_free;
    logic                  accept;
    logic                  grant_found;
    logic [ID_W-1:0]       grant_id;

    // Per-requester operand views and one-hot response decode
    logic [DATA_WIDTH-1:0] op_a [NUM_REQ];
    logic [DATA_WIDTH-1:0] op_b [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign op_a[gi]      = req_a[gi*DATA_WIDTH +: DATA_WIDTH];
            assign op_b[gi]      = req_b[gi*DATA_WIDTH +: DATA_WIDTH];
            assign rsp_valid[gi] = s2_valid_q && (s2_id_q == ID_W'(gi));
        end
    endgenerate

    // Stage drain/advance conditions; S2's owner is the only set rsp_valid bit
    always_comb begin
        s2_drain = s2_valid_q && (|(rsp_valid & rsp_ready));
        s2_free  = !s2_valid_q || s2_drain;
        s1_adv   = s1_valid_q && s2_free;
        s1_free  = !s1_valid_q || s1_adv;
    end

`ifdef FMUL_ARB_RR_EN
    // Round-robin search starting at rr_ptr, wrapping at NUM_REQ
    always_comb begin
        logic [ID_W:0] cand;
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[ID_W-1:0];
            end
        end
    end
`else
    // Fixed priority: scan downwards so the lowest requesting index wins
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(k);
            end
        end
    end
`endif

    // One-hot grant, only while S1 can take a new operand pair and out of reset
    always_comb begin
        req_ready = '0;
        if (rst_n && s1_free && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
        accept = |(req_valid & req_ready);
    end

    // Next-state for both stages (and the round-robin pointer when present)
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;
`ifdef FMUL_ARB_RR_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = op_a[grant_id];
            s1_b_d     = op_b[grant_id];
            s1_id_d    = grant_id;
`ifdef FMUL_ARB_RR_EN
            rr_ptr_d   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
`endif
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        // The product is captured as S1 hands over; rsp_data holds otherwise
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_data_d  = mul_out;
            s2_id_d    = s1_id_q;
        end else if (s2_drain) begin
            s2_valid_d = 1'b0;
        end
    end

    // State registers; reset discards everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
`ifdef FMUL_ARB_RR_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_id_q    <= s2_id_d;
`ifdef FMUL_ARB_RR_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    // Multiplier inputs are forced to zero while S1 is empty
    always_comb begin
        mul_in1  = s1_valid_q ? s1_a_q : '0;
        mul_in2  = s1_valid_q ? s1_b_q : '0;
        rsp_data = s2_data_q;
        busy     = s1_valid_q || s2_valid_q;
    end

endmodule
